// File: rtl/serializer4_pkg.sv
// Shared types and constants for the four-word serializer.
package serializer4_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned NUM_WORDS     = 4;
  localparam int unsigned IDX_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serializer4_if.sv
// Request/emit bus between a word producer and the serializer.
interface serializer4_if #(
  parameter int unsigned WIDTH = serializer4_pkg::WIDTH_DEFAULT
);

  logic                               start;
  logic [WIDTH-1:0]                   in_a;
  logic [WIDTH-1:0]                   in_b;
  logic [WIDTH-1:0]                   in_c;
  logic [WIDTH-1:0]                   in_d;
  logic                               out_ready;
  logic [WIDTH-1:0]                   out_data;
  logic                               out_valid;
  logic [serializer4_pkg::IDX_W-1:0]  out_sel;
  logic                               busy;
  logic                               done;

  modport master (
    output start, in_a, in_b, in_c, in_d, out_ready,
    input  out_data, out_valid, out_sel, busy, done
  );

  modport slave (
    input  start, in_a, in_b, in_c, in_d, out_ready,
    output out_data, out_valid, out_sel, busy, done
  );

endinterface

// File: rtl/serializer4_mux4.sv
// Four-way word selector driven by the serializer's word index.
module mux4 #(
  parameter int unsigned WIDTH = serializer4_pkg::WIDTH_DEFAULT
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] word_c_o
);

  always_comb begin
    word_c_o = d0_i;
    unique case (sel_i)
      2'd0:    word_c_o = d0_i;
      2'd1:    word_c_o = d1_i;
      2'd2:    word_c_o = d2_i;
      2'd3:    word_c_o = d3_i;
      default: word_c_o = d0_i;
    endcase
  end

endmodule

// File: rtl/serializer4.sv
// Captures four words on start and emits them a..d over a valid/ready
// handshake, then pulses done for one cycle before returning to IDLE.
module serializer4
  import serializer4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  serializer4_if.slave     bus
);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q,   idx_d;
  logic [NUM_WORDS-1:0][WIDTH-1:0] words_q, words_d;
  logic [WIDTH-1:0]                mux_word;
  logic                            send_c;

  // State, index and captured words; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
    end
  end

  // Next-state: start only matters in IDLE, so inputs are frozen once captured.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    words_d = words_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          words_d = {bus.in_d, bus.in_c, bus.in_b, bus.in_a};
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .sel_i    (idx_q),
    .d0_i     (words_q[0]),
    .d1_i     (words_q[1]),
    .d2_i     (words_q[2]),
    .d3_i     (words_q[3]),
    .word_c_o (mux_word)
  );

  // Outputs decode registered state only; data/sel read as zero outside SEND.
  assign send_c        = (state_q == SEND);
  assign bus.out_valid = send_c;
  assign bus.out_data  = send_c ? mux_word : '0;
  assign bus.out_sel   = send_c ? idx_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_serializer4.sv
// Bench for serializer4: directed scenarios plus random traffic against a
// queue-based reference model of the word emission.
module tb_serializer4;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n;

  serializer4_if #(.WIDTH(W)) bus ();

  serializer4 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: words still to emit, and a pending done pulse.
  logic [W-1:0] mq[$];
  bit           m_done;

  localparam logic [W-1:0] WA = 32'h1111_1111;
  localparam logic [W-1:0] WB = 32'h2222_2222;
  localparam logic [W-1:0] WC = 32'h3333_3333;
  localparam logic [W-1:0] WD = 32'h4444_4444;

  function automatic logic [W+4:0] exp_vec();
    logic v;
    logic [1:0] s;
    logic [W-1:0] d;
    v = (mq.size() != 0);
    s = 2'd0;
    d = '0;
    if (v) begin
      s = 2'(4 - mq.size());
      d = mq[0];
    end
    return {v, s, d, v | m_done, m_done};
  endfunction

  function automatic logic [W+4:0] act_vec();
    return {bus.out_valid, bus.out_sel, bus.out_data, bus.busy, bus.done};
  endfunction

  function automatic void model_step(input bit rn, input bit st, input bit rdy,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] c, input logic [W-1:0] d);
    if (!rn) begin
      mq.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (st) begin
      mq = {a, b, c, d};
    end
  endfunction

  // Apply inputs at a falling edge, advance the model, wait one full cycle.
  task automatic drive(input bit rn, input bit st, input bit rdy,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    reset_n       = rn;
    bus.start     = st;
    bus.out_ready = rdy;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_c      = c;
    bus.in_d      = d;
    model_step(rn, st, rdy, a, b, c, d);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [W-1:0] rw();
    return W'($urandom());
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    checks++;
    if (act_vec() !== '0) begin
      errors++;
      $display("FAIL reset_zero act=%h exp=0", act_vec());
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] got[$];
    int dn = 0;
    drive(1'b1, 1'b1, 1'b1, WA, WB, WC, WD);
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stream_first cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
    end
    for (int i = 0; i < 7; i++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stream cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if (got.size() != 4 || {got[0], got[1], got[2], got[3]} !== {WA, WB, WC, WD}) begin
      errors++;
      $display("FAIL stream_words got %0d words, expected a,b,c,d", got.size());
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL stream_done pulses=%0d exp=1", dn);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    int hold = 0;
    bit rdy;
    drive(1'b1, 1'b1, 1'b1, WA, WB, WC, WD);
    for (int i = 0; i < 12; i++) begin
      rdy = 1'b1;
      if (bus.out_sel === 2'd1 && bus.out_valid === 1'b1 && hold < 3) begin
        rdy = 1'b0;
        hold++;
        checks++;
        if (bus.out_data !== WB || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold data=%h valid=%b exp=%h/1", bus.out_data, bus.out_valid, WB);
        end
      end
      if (bus.out_valid === 1'b1 && rdy) got.push_back(bus.out_data);
      drive(1'b1, 1'b0, rdy, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    checks++;
    if (hold != 3 || got.size() != 4 ||
        {got[0], got[1], got[2], got[3]} !== {WA, WB, WC, WD}) begin
      errors++;
      $display("FAIL bp_seq stalls=%0d words=%0d exp 3 and 4", hold, got.size());
    end
  endtask

  task automatic test_isolation();
    logic [W-1:0] orig[4];
    logic [W-1:0] got[$];
    int dn = 0;
    bit rdy;
    foreach (orig[k]) orig[k] = rw();
    drive(1'b1, 1'b1, 1'b1, orig[0], orig[1], orig[2], orig[3]);
    for (int i = 0; i < 20; i++) begin
      rdy = 1'($urandom_range(0, 3) != 0);
      if (bus.out_valid === 1'b1 && rdy) got.push_back(bus.out_data);
      // Keep start asserted through SEND and DONE only.
      drive(1'b1, bus.busy === 1'b1, rdy, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL iso cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if (dn != 1 || got.size() != 4 ||
        {got[0], got[1], got[2], got[3]} !== {orig[0], orig[1], orig[2], orig[3]}) begin
      errors++;
      $display("FAIL iso_words done=%0d words=%0d exp 1 and 4 captured", dn, got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] nw[4];
    logic [W-1:0] got[$];
    int dn = 0;
    bit found = 1'b0;
    drive(1'b1, 1'b1, 1'b1, rw(), rw(), rw(), rw());
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.out_sel === 2'd2) found = 1'b1;
      else drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach sel=%0d exp=2", bus.out_sel);
    end
    drive(1'b0, 1'b1, 1'b1, rw(), rw(), rw(), rw());
    checks++;
    if (act_vec() !== '0) begin
      errors++;
      $display("FAIL rstmid_zero act=%h exp=0", act_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_idle cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (bus.done === 1'b1) dn++;
    end
    foreach (nw[k]) nw[k] = rw();
    drive(1'b1, 1'b1, 1'b1, nw[0], nw[1], nw[2], nw[3]);
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_fresh cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
    checks++;
    if (dn != 0 || got.size() != 4 ||
        {got[0], got[1], got[2], got[3]} !== {nw[0], nw[1], nw[2], nw[3]}) begin
      errors++;
      $display("FAIL rstmid_restart stray_done=%0d words=%0d exp 0 and 4", dn, got.size());
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int n    = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 1'b1, rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (bus.done === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++;
            $display("FAIL b2b_period act=%0d exp=6", cyc - last);
          end
        end
        last = cyc;
        n++;
      end
    end
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL b2b_count done=%0d exp>=6", n);
    end
  endtask

  task automatic test_random();
    bit rn;
    for (int i = 0; i < 500; i++) begin
      rn = 1'($urandom_range(0, 49) != 0);
      drive(rn, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) < 3),
            rw(), rw(), rw(), rw());
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, rw(), rw(), rw(), rw());
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer4.md
SERIALIZER4 -- requirements
Module: serializer4

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of each data word.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to capture the four input words and begin emission; sampled only in IDLE.
REQ-005 in_a, in_b, in_c, in_d  input  WIDTH each  words to emit; emitted in order a, b, c, d.
REQ-006 out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 out_data  output  WIDTH  current word being offered.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_sel  output  2  index of the offered word: 0 = a, 1 = b, 2 = c, 3 = d.
REQ-010 busy  output  1  high in SEND and DONE.
REQ-011 done  output  1  single-cycle pulse after the fourth word transfers.

Function
REQ-012 The block SHALL use three states: IDLE, SEND and DONE.
REQ-013 IDLE with start=1: capture in_a..in_d into internal word registers, set index to 0 and go to SEND on the next edge.
REQ-014 IDLE with start=0: stay in IDLE; outputs hold their reset values.
REQ-015 SEND: out_valid=1; out_data is the word register selected by index; out_sel equals index.
REQ-016 A transfer occurs in any SEND cycle where out_valid=1 and out_ready=1.
REQ-017 Transfer with index<3: index increments by 1 and the block stays in SEND.
REQ-018 Transfer with index=3: go to DONE; index does not wrap and is not reused.
REQ-019 SEND with out_ready=0: out_data, out_sel and out_valid remain stable until a transfer occurs.
REQ-020 DONE: out_valid=0 and done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-021 start SHALL be ignored in SEND and DONE, and in_a..in_d changes there SHALL NOT affect emitted data.
REQ-022 Latency: start sampled at edge N gives out_valid=1 with word a after edge N; with out_ready held high, four transfers complete in 4 consecutive cycles and done pulses in the 5th cycle.
REQ-023 A new start is accepted no earlier than the first IDLE cycle following DONE, so minimum start-to-start spacing is 6 cycles.
REQ-024 out_valid, busy and done SHALL be decoded from registered state only; there SHALL be no combinational path from out_ready to out_valid.

Reset
REQ-025 reset_n=0 at a clock edge: state=IDLE, index=0, all word registers=0.
REQ-026 During and immediately after reset: out_data=0, out_valid=0, out_sel=0, busy=0, done=0.
REQ-027 Reset SHALL take priority over start and out_ready in the same cycle.
REQ-028 Reset during SEND or DONE SHALL abandon the sequence with no done pulse; the next emission requires a fresh start.

Structure
REQ-029 A shared package serializer4_pkg SHALL hold the state enum typedef (IDLE, SEND, DONE) and the default WIDTH constant 32.
REQ-030 Word selection SHALL be a sub-module mux4, parameterised by WIDTH: 2-bit select, four inputs, one output.
REQ-031 The FSM, index counter and word registers SHALL live in serializer4; no other sub-modules.

Verification
REQ-032 Streaming: reset, then start with a=0x11111111, b=0x22222222, c=0x33333333, d=0x44444444, out_ready=1 -> out_data = a, b, c, d on 4 consecutive cycles with out_sel 0..3, then done=1 for one cycle, then IDLE.
REQ-033 Backpressure: same words, out_ready=0 for 3 cycles while out_sel=1 -> out_data holds 0x22222222 and out_valid stays 1 throughout; the sequence then resumes with c and d.
REQ-034 Input isolation: change in_a..in_d and pulse start mid-SEND -> emitted words are the originally captured values and no second sequence starts.
REQ-035 Reset mid-operation: assert reset_n=0 while out_sel=2 -> next cycle all outputs are 0 and there is no done pulse; a fresh start then emits from word a.
REQ-036 Back-to-back: hold start=1 continuously with out_ready=1 -> a new capture occurs in the first IDLE cycle after each DONE, giving a 6-cycle period.
REQ-037 Reset priority: assert start=1 and reset_n=0 in the same cycle -> block remains in IDLE with out_valid=0.
